// File: rtl/ucounter_pkg.sv
// Shared definitions for the utimer_n counter/timer: terminal-count modes and
// the RUN/HALT state encoding.
package ucounter_pkg;

   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_STOP   = 2'b01;
   localparam logic [1:0] MODE_RELOAD = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage

// File: rtl/uprescaler.sv
// Programmable tick divider: one tick every (prescale+1) enabled cycles.
// clr zeroes the divider and suppresses the tick in the same cycle.
module uprescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  _areset,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] psc_reg;
   logic                  hit;

   // A psc already above a freshly lowered prescale keeps counting and wraps
   assign hit  = (psc_reg == prescale);
   assign tick = en & ~clr & hit;

   always_ff @(posedge clk or negedge _areset) begin
      if (!_areset) begin
         psc_reg <= '0;
      end else if (clr) begin
         psc_reg <= '0;
      end else if (en) begin
         psc_reg <= hit ? '0 : psc_reg + 1'b1;
      end
   end

endmodule

// File: rtl/utimer_n.sv
// WIDTH-bit up/down counter/timer with prescaler, WRAP/STOP/RELOAD terminal
// modes, sticky and pulsed overflow, compare-match pulse and a HALT state.
module utimer_n
   import ucounter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  _areset,
   input  logic                  en,
   input  logic                  load,
   input  logic [WIDTH-1:0]      preld_val,
   input  logic                  up,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      cmp_val,
   input  logic                  ovf_clr,
   output logic [WIDTH-1:0]      dcount,
   output logic                  overflow,
   output logic                  ovf_pulse,
   output logic                  cmp_match,
   output logic                  running
);

   localparam logic [WIDTH-1:0] MAX = '1;

   state_t           state_reg, state_next;
   logic             tick;
   logic             terminal;
   logic [WIDTH-1:0] count_next;

   // Holding the divider clear during HALT also suppresses ticks there
   uprescaler #(.PRESCALE_W(PRESCALE_W)) u_psc (
      .clk      (clk),
      ._areset  (_areset),
      .en       (en),
      .clr      (load | (state_reg == ST_HALT)),
      .prescale (prescale),
      .tick     (tick)
   );

   always_comb begin
      terminal   = up ? (dcount == MAX) : (dcount == '0);
      count_next = up ? dcount + 1'b1 : dcount - 1'b1;
      state_next = state_reg;
      if (terminal) begin
         case (mode)
            MODE_STOP:   count_next = dcount;
            MODE_RELOAD: count_next = preld_val;
            default:     count_next = up ? '0 : MAX;
         endcase
      end
      if (load) begin
         state_next = ST_RUN;
      end else if (tick && terminal && (mode == MODE_STOP)) begin
         state_next = ST_HALT;
      end
   end

   always_ff @(posedge clk or negedge _areset) begin
      if (!_areset) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge _areset) begin
      if (!_areset) begin
         dcount    <= '0;
         ovf_pulse <= 1'b0;
         cmp_match <= 1'b0;
      end else if (load) begin
         dcount    <= preld_val;
         ovf_pulse <= 1'b0;
         cmp_match <= 1'b0;
      end else if (tick) begin
         dcount    <= count_next;
         ovf_pulse <= terminal;
         cmp_match <= (count_next == cmp_val);
      end else begin
         ovf_pulse <= 1'b0;
         cmp_match <= 1'b0;
      end
   end

   // A terminal tick beats a simultaneous clear
   always_ff @(posedge clk or negedge _areset) begin
      if (!_areset) begin
         overflow <= 1'b0;
      end else if (tick && terminal && !load) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   assign running = (state_reg == ST_RUN);

endmodule

// File: tb/tb_utimer_n.sv
// Directed scoreboard bench for utimer_n: stimulus queues expected outputs
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_utimer_n;
   import ucounter_pkg::*;

   typedef enum int {F_DCOUNT, F_OVF, F_PULSE, F_CMP, F_RUN} field_t;

   typedef struct {
      int     cyc;
      string  name;
      field_t field;
      int     value;
   } exp_t;

   logic       clk = 1'b0;
   logic       areset_n;
   logic       en;
   logic       load;
   logic [7:0] preld_val;
   logic       up;
   logic [1:0] mode;
   logic [3:0] prescale;
   logic [7:0] cmp_val;
   logic       ovf_clr;
   logic [7:0] dcount;
   logic       overflow;
   logic       ovf_pulse;
   logic       cmp_match;
   logic       running;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t e;
   int   act;

   utimer_n #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk       (clk),
      ._areset   (areset_n),
      .en        (en),
      .load      (load),
      .preld_val (preld_val),
      .up        (up),
      .mode      (mode),
      .prescale  (prescale),
      .cmp_val   (cmp_val),
      .ovf_clr   (ovf_clr),
      .dcount    (dcount),
      .overflow  (overflow),
      .ovf_pulse (ovf_pulse),
      .cmp_match (cmp_match),
      .running   (running)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int fetch(field_t f);
      case (f)
         F_DCOUNT: return int'(dcount);
         F_OVF:    return int'(overflow);
         F_PULSE:  return int'(ovf_pulse);
         F_CMP:    return int'(cmp_match);
         default:  return int'(running);
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e   = sb.pop_front();
         act = fetch(e.field);
         n_checks++;
         if (e.cyc != cyc || act != e.value) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (due cycle %0d, now %0d)",
                     e.name, act, e.value, e.cyc, cyc);
         end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", e.name, act, cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input field_t f, input int v);
      exp_t x;
      x.cyc   = cyc;
      x.name  = name;
      x.field = f;
      x.value = v;
      sb.push_back(x);
   endtask

   initial begin
      areset_n  = 1'b0;
      en        = 1'b0;
      load      = 1'b0;
      preld_val = 8'h00;
      up        = 1'b0;
      mode      = MODE_WRAP;
      prescale  = 4'd0;
      cmp_val   = 8'hAA;
      ovf_clr   = 1'b0;

      // Power-on reset
      step(2);
      chk("rst_dcount", F_DCOUNT, 0);
      chk("rst_ovf",    F_OVF,    0);
      chk("rst_pulse",  F_PULSE,  0);
      chk("rst_cmp",    F_CMP,    0);
      chk("rst_run",    F_RUN,    1);
      @(negedge clk);
      #1 areset_n = 1'b1;

      // Reset in the middle of counting
      load = 1'b1; preld_val = 8'h5A;
      step(1);
      load = 1'b0; en = 1'b1; up = 1'b1;
      chk("load_5a", F_DCOUNT, 'h5A);
      step(1);
      areset_n = 1'b0;
      chk("midrst_dcount", F_DCOUNT, 0);
      chk("midrst_ovf",    F_OVF,    0);
      chk("midrst_run",    F_RUN,    1);
      @(negedge clk);
      #1 areset_n = 1'b1;
      step(1);
      chk("first_tick", F_DCOUNT, 1);

      // WRAP with prescale=2 from 0xFE
      load = 1'b1; preld_val = 8'hFE; prescale = 4'd2; mode = MODE_WRAP;
      step(1);
      load = 1'b0;
      chk("wrap_load", F_DCOUNT, 'hFE);
      step(2);
      chk("wrap_psc_wait", F_DCOUNT, 'hFE);
      step(1);
      chk("wrap_ff",       F_DCOUNT, 'hFF);
      chk("wrap_ff_pulse", F_PULSE,  0);
      step(2);
      chk("wrap_ff_hold", F_DCOUNT, 'hFF);
      step(1);
      chk("wrap_00",       F_DCOUNT, 0);
      chk("wrap_ovf",      F_OVF,    1);
      chk("wrap_pulse",    F_PULSE,  1);
      chk("wrap_cmp",      F_CMP,    0);
      step(1);
      chk("wrap_pulse_end", F_PULSE, 0);
      chk("wrap_ovf_stick", F_OVF,   1);

      // STOP counting down to zero
      load = 1'b1; preld_val = 8'h01; mode = MODE_STOP; up = 1'b0;
      prescale = 4'd0; ovf_clr = 1'b1;
      step(1);
      load = 1'b0; ovf_clr = 1'b0;
      chk("stop_load",     F_DCOUNT, 1);
      chk("stop_ovf_clr",  F_OVF,    0);
      step(1);
      chk("stop_zero",     F_DCOUNT, 0);
      chk("stop_zero_run", F_RUN,    1);
      step(1);
      chk("stop_hold",     F_DCOUNT, 0);
      chk("stop_halt",     F_RUN,    0);
      chk("stop_ovf",      F_OVF,    1);
      chk("stop_pulse",    F_PULSE,  1);
      step(3);
      chk("halt_dcount",   F_DCOUNT, 0);
      chk("halt_run",      F_RUN,    0);
      chk("halt_pulse",    F_PULSE,  0);
      load = 1'b1; preld_val = 8'h10;
      step(1);
      load = 1'b0; en = 1'b0;
      chk("resume_run",    F_RUN,    1);
      chk("resume_dcount", F_DCOUNT, 'h10);
      chk("resume_ovf",    F_OVF,    1);

      // RELOAD terminal landing on cmp_val
      load = 1'b1; preld_val = 8'hFF;
      step(1);
      load = 1'b0; preld_val = 8'hF0; mode = MODE_RELOAD; up = 1'b1;
      cmp_val = 8'hF0; en = 1'b1;
      chk("rel_load", F_DCOUNT, 'hFF);
      step(1);
      en = 1'b0;
      chk("rel_dcount", F_DCOUNT, 'hF0);
      chk("rel_pulse",  F_PULSE,  1);
      chk("rel_cmp",    F_CMP,    1);
      chk("rel_ovf",    F_OVF,    1);
      step(1);
      chk("rel_cmp_end",   F_CMP,    0);
      chk("rel_pulse_end", F_PULSE,  0);
      chk("rel_hold",      F_DCOUNT, 'hF0);

      // ovf_clr loses to a simultaneous terminal tick
      load = 1'b1; preld_val = 8'hFF; mode = MODE_WRAP;
      step(1);
      load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
      chk("clr_load", F_DCOUNT, 'hFF);
      step(1);
      en = 1'b0;
      chk("clr_race_dcount", F_DCOUNT, 0);
      chk("clr_race_ovf",    F_OVF,    1);
      chk("clr_race_pulse",  F_PULSE,  1);
      step(1);
      ovf_clr = 1'b0;
      chk("clr_alone_ovf", F_OVF, 0);

      // Load beats a same-cycle tick; en=0 freezes everything
      en = 1'b1; up = 1'b1; prescale = 4'd0; load = 1'b1;
      preld_val = 8'h33; cmp_val = 8'h33;
      step(1);
      load = 1'b0; en = 1'b0;
      chk("lt_dcount", F_DCOUNT, 'h33);
      chk("lt_cmp",    F_CMP,    0);
      step(5);
      chk("frozen_dcount", F_DCOUNT, 'h33);
      en = 1'b1; prescale = 4'd2;
      step(2);
      chk("frozen_psc", F_DCOUNT, 'h33);
      step(1);
      chk("thaw_tick", F_DCOUNT, 'h34);
      chk("thaw_cmp",  F_CMP,    0);
      prescale = 4'd0; up = 1'b0;
      step(1);
      en = 1'b0;
      chk("down_dcount", F_DCOUNT, 'h33);
      chk("down_cmp",    F_CMP,    1);
      step(1);
      chk("down_cmp_end", F_CMP, 0);

      step(3);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
